uart_rx_ctrl: RTL and testbench

Receive-side controller of the UART RX path: detects the start bit on the raw line, times every bit with an oversampling edge counter and a bit counter, and issues the per-bit enable strobes to the data sampler, start/parity/stop checkers and deserializer. It sits directly upstream of `parity_check` and drives its `par_chk_en`. It also raises `data_valid` when a complete error-free frame has been received.

---
 rtl/uart_rx_pkg.sv | 23 ++
 rtl/uart_rx_ctrl_if.sv | 35 +++
 rtl/uart_edge_bit_counter.sv | 50 +++++
 rtl/uart_rx_ctrl.sv | 137 +++++++++++++
 tb/tb_uart_rx_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// UART RX controller shared definitions: FSM state encoding, frame
// constants and the sample-point helper used by the controller.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    localparam int DATA_BITS     = 8;
    localparam int BIT_START     = 0;
    localparam int BIT_LAST_DATA = 8;

    // First oversample edge at which the sampler's registered
    // majority bit is valid.
    function automatic int unsigned sample_point(input int unsigned prescale);
        return prescale / 2 + 2;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the RX controller and its datapath neighbours.
// master: controller side (line, config and checker results in; counters and strobes out).
// slave : datapath side (the mirror image).
interface uart_rx_ctrl_if #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_W      = 4
);
    logic                  rx_in;
    logic                  par_en;
    logic [PRESCALE_W-1:0] prescale;
    logic                  strt_glitch;
    logic                  par_err;
    logic                  stp_err;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  dat_samp_en;
    logic                  strt_chk_en;
    logic                  par_chk_en;
    logic                  stp_chk_en;
    logic                  deser_en;
    logic                  data_valid;

    modport master (
        input  rx_in, par_en, prescale, strt_glitch, par_err, stp_err,
        output edge_cnt, bit_cnt, dat_samp_en, strt_chk_en,
        output par_chk_en, stp_chk_en, deser_en, data_valid
    );

    modport slave (
        output rx_in, par_en, prescale, strt_glitch, par_err, stp_err,
        input  edge_cnt, bit_cnt, dat_samp_en, strt_chk_en,
        input  par_chk_en, stp_chk_en, deser_en, data_valid
    );

endinterface

// File: rtl/uart_edge_bit_counter.sv
// Oversample edge counter and frame bit counter.
// Ports: clk, rst (sync active-low), enable (0 clears both counters),
// prescale (edges per bit), edge_cnt, bit_cnt, bit_done (last edge of bit).
module uart_edge_bit_counter #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]      bit_cnt,
    output logic                  bit_done
);

    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;

    // >= rather than == so an out-of-range prescale still wraps.
    assign bit_done = (edge_cnt_q >= (prescale - PRESCALE_W'(1)));

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (!enable) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (bit_done) begin
            edge_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + BIT_W'(1);
        end else begin
            edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
    assign bit_cnt  = bit_cnt_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX controller: start detection, bit timing and per-bit strobes.
// Ports: clk, rst (sync active-low), bus (uart_rx_ctrl_if.master).
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6,
    parameter int BIT_W      = 4
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_ctrl_if.master bus
);

    rx_state_e             state_q, state_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  par_en_q, par_en_d;
    logic                  par_flag_q, par_flag_d;
    logic                  stp_flag_q, stp_flag_d;

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  bit_done;
    logic                  cnt_en;
    logic [PRESCALE_W-1:0] sp, sp1;
    logic                  at_sp, at_sp1;

    logic strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid;

    assign sp     = PRESCALE_W'(sample_point(32'(presc_q)));
    assign sp1    = sp + PRESCALE_W'(1);
    assign at_sp  = (edge_cnt == sp);
    assign at_sp1 = (edge_cnt == sp1);

    // Counters run only while staying inside a frame, so they read 0
    // on the first START cycle and on the first IDLE cycle.
    assign cnt_en = (state_q != ST_IDLE) && (state_d != ST_IDLE);

    uart_edge_bit_counter #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_W      (BIT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .enable   (cnt_en),
        .prescale (presc_q),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_done (bit_done)
    );

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        par_en_d    = par_en_q;
        par_flag_d  = par_flag_q;
        stp_flag_d  = stp_flag_q;
        strt_chk_en = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        deser_en    = 1'b0;
        data_valid  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!bus.rx_in) begin
                    state_d    = ST_START;
                    presc_d    = bus.prescale;
                    par_en_d   = bus.par_en;
                    par_flag_d = 1'b0;
                    stp_flag_d = 1'b0;
                end
            end
            ST_START: begin
                strt_chk_en = at_sp && (bit_cnt == BIT_W'(BIT_START));
                if (bit_done) begin
                    state_d = bus.strt_glitch ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                deser_en   = at_sp;
                par_chk_en = at_sp;
                if (bit_done && (bit_cnt == BIT_W'(BIT_LAST_DATA))) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                par_chk_en = at_sp;
                if (at_sp1) begin
                    par_flag_d = bus.par_err;
                end
                if (bit_done) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                stp_chk_en = at_sp;
                if (at_sp1) begin
                    stp_flag_d = bus.stp_err;
                end
                if (bit_done) begin
                    state_d = ST_IDLE;
                    // Uses the next-state flag: at prescale 8 the stop
                    // error lands on the very last edge of the bit.
                    data_valid = !stp_flag_d && (!par_en_q || !par_flag_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            par_en_q   <= 1'b0;
            par_flag_q <= 1'b0;
            stp_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            par_en_q   <= par_en_d;
            par_flag_q <= par_flag_d;
            stp_flag_q <= stp_flag_d;
        end
    end

    assign bus.edge_cnt    = edge_cnt;
    assign bus.bit_cnt     = bit_cnt;
    assign bus.dat_samp_en = (state_q != ST_IDLE);
    assign bus.strt_chk_en = strt_chk_en;
    assign bus.par_chk_en  = par_chk_en;
    assign bus.stp_chk_en  = stp_chk_en;
    assign bus.deser_en    = deser_en;
    assign bus.data_valid  = data_valid;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed and random frames
// compared cycle by cycle against an arithmetic frame model.
module tb_uart_rx_ctrl;

    localparam int PW = 6;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   dv_abs = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    uart_rx_ctrl_if #(.PRESCALE_W(PW), .BIT_W(BW)) bus ();

    uart_rx_ctrl #(.PRESCALE_W(PW), .BIT_W(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] outs();
        return {bus.edge_cnt, bus.bit_cnt, bus.dat_samp_en, bus.strt_chk_en,
                bus.par_chk_en, bus.stp_chk_en, bus.deser_en, bus.data_valid};
    endfunction

    // Expected outputs at offset k from START entry, from frame arithmetic.
    function automatic logic [15:0] model(input int p, input bit pe, input bit gl,
                                          input bit ok, input int k);
        int b, e, sp, nb, len;
        logic st, pc, sc, de, dv;
        b   = k / p;
        e   = k % p;
        sp  = p / 2 + 2;
        nb  = pe ? 11 : 10;
        len = gl ? p : nb * p;
        st  = (b == 0) && (e == sp);
        de  = !gl && (b >= 1) && (b <= 8) && (e == sp);
        pc  = de || (pe && (b == 9) && (e == sp));
        sc  = !gl && (b == nb - 1) && (e == sp);
        dv  = ok && !gl && (k == len - 1);
        return {6'(e), 4'(b), 1'b1, st, pc, sc, de, dv};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle", 32'(outs()), 32'h0);
            @(posedge clk); #1;
            bus.rx_in       = 1'b1;
            bus.strt_glitch = 1'($urandom);
            bus.par_err     = 1'($urandom);
            bus.stp_err     = 1'($urandom);
        end
    endtask

    // Entered just after a clock edge; rx falls in this cycle.
    task automatic frame(input int p, input bit pe, input logic [7:0] byt,
                         input bit gl, input bit perr, input bit serr,
                         input int rst_at);
        int sp, nb, len, lim, b, e, npc, nde, ndv, dv_at;
        bit ok;
        logic line;
        logic [7:0] got;
        logic [15:0] exp;
        sp    = p / 2 + 2;
        nb    = pe ? 11 : 10;
        len   = gl ? p : nb * p;
        lim   = (rst_at >= 0) ? rst_at + 2 : len;
        ok    = !serr && !(pe && perr);
        npc   = 0;
        nde   = 0;
        ndv   = 0;
        dv_at = -1;
        got   = '0;
        bus.rx_in    = 1'b0;
        bus.prescale = PW'(p);
        bus.par_en   = pe;
        @(negedge clk);
        chk("pre_idle", 32'(outs()), 32'h0);
        for (int k = 0; k < lim; k++) begin
            b = k / p;
            e = k % p;
            @(posedge clk); #1;
            bus.prescale = PW'($urandom);
            bus.par_en   = 1'($urandom);
            if (b == 0)               line = gl ? (k >= 2) : 1'b0;
            else if (b <= 8)          line = byt[b-1];
            else if (b == 9 && pe)    line = ^byt;
            else                      line = 1'b1;
            if (rst_at >= 0 && k > rst_at) line = 1'b1;
            bus.rx_in       = line;
            bus.strt_glitch = (b == 0 && e == p - 1) ? gl : 1'($urandom);
            bus.par_err     = (pe && b == 9 && e == sp + 1) ? perr : 1'($urandom);
            bus.stp_err     = (b == nb - 1 && e == sp + 1) ? serr : 1'($urandom);
            rst = (rst_at >= 0 && k == rst_at) ? 1'b0 : 1'b1;
            @(negedge clk);
            exp = (rst_at >= 0 && k > rst_at) ? 16'h0 : model(p, pe, gl, ok, k);
            chk($sformatf("p%0d k%0d", p, k), 32'(outs()), 32'(exp));
            if (bus.par_chk_en) npc++;
            if (bus.deser_en) begin
                nde++;
                got = {line, got[7:1]};
            end
            if (bus.data_valid) begin
                ndv++;
                dv_at  = k;
                dv_abs = cyc;
            end
        end
        @(posedge clk); #1;
        rst          = 1'b1;
        bus.rx_in    = 1'b1;
        bus.prescale = PW'(p);
        if (rst_at >= 0) begin
            chk("rst_dv", 32'(ndv), 32'd0);
        end else if (gl) begin
            chk("gl_par", 32'(npc), 32'd0);
            chk("gl_deser", 32'(nde), 32'd0);
            chk("gl_dv", 32'(ndv), 32'd0);
        end else begin
            chk("n_par", 32'(npc), pe ? 32'd9 : 32'd8);
            chk("n_deser", 32'(nde), 32'd8);
            chk("byte", 32'(got), 32'(byt));
            chk("dv_at", 32'(dv_at), ok ? 32'(len - 1) : 32'hFFFF_FFFF);
        end
    endtask

    initial begin
        int first_dv, pr;
        bit pe, b2b;
        bus.rx_in       = 1'b1;
        bus.par_en      = 1'b0;
        bus.prescale    = PW'(16);
        bus.strt_glitch = 1'b0;
        bus.par_err     = 1'b0;
        bus.stp_err     = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            bus.rx_in = 1'($urandom);
            @(negedge clk);
            chk("reset", 32'(outs()), 32'h0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        bus.rx_in = 1'b1;
        idle(2);

        frame(16, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, -1);
        idle(1);
        frame(8, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, -1);
        idle(1);
        frame(16, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, -1);
        idle(2);

        frame(32, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, -1);
        first_dv = dv_abs;
        frame(32, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, -1);
        chk("b2b_gap", 32'(dv_abs - first_dv), 32'd353);
        idle(1);

        frame(16, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 5 * 16 + 3);
        idle(1);
        frame(16, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, -1);
        idle(1);
        frame(8, 1'b0, 8'h81, 1'b0, 1'b0, 1'b1, -1);
        idle(1);
        frame(8, 1'b0, 8'h7E, 1'b0, 1'b1, 1'b0, -1);
        idle(1);

        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 2))
                0:       pr = 8;
                1:       pr = 16;
                default: pr = 32;
            endcase
            pe  = 1'($urandom);
            b2b = 1'($urandom);
            frame(pr, pe, 8'($urandom), ($urandom_range(0, 7) == 0),
                  1'($urandom), ($urandom_range(0, 3) == 0), -1);
            if (!b2b) idle(1);
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
